// File: rtl/ballot_unit.sv
// Voter-side ballot capture: synchronises and debounces the party buttons, then
// accepts exactly one vote per issued ballot and emits a registered vote strobe.
`timescale 1ns/1ps

module ballot_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       enable_ballot,
  input  logic [3:0] party_btn,
  output logic       ballot_ready,
  output logic       vote_valid,
  output logic [1:0] incr_party_vote,
  output logic       invalid_press,
  output logic       timeout
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2,
    LOCK  = 2'd3
  } state_t;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] deb_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 4'b0000;
      sync2_reg <= 4'b0000;
    end else begin
      sync1_reg <= party_btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Each button flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_reg;
      logic            deb_bit_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg     <= '0;
          deb_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg     <= '0;
          deb_bit_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end

      assign deb_state[gi] = deb_bit_reg;
    end
  endgenerate

  logic       btn_none;
  logic       btn_onehot;
  logic [1:0] btn_index;

  assign btn_none   = (deb_state == 4'b0000);
  assign btn_onehot = !btn_none && ((deb_state & (deb_state - 4'd1)) == 4'b0000);
  assign btn_index  = {deb_state[3] | deb_state[2], deb_state[3] | deb_state[1]};

  state_t          state_reg, state_next;
  logic [TO_W-1:0] tmo_reg, tmo_next;
  logic [1:0]      idx_reg, idx_next;
  logic            ready_next;
  logic            vote_next;
  logic            invalid_next;
  logic            timeout_next;
  logic            expired;

  assign expired = (tmo_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next   = state_reg;
    tmo_next     = tmo_reg;
    idx_next     = idx_reg;
    vote_next    = 1'b0;
    invalid_next = 1'b0;
    timeout_next = 1'b0;

    if (!mode) begin
      // Result mode discards any pending ballot and silences all pulses.
      state_next = IDLE;
      tmo_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable_ballot) begin
            state_next = CLEAR;
            tmo_next   = '0;
          end
        end
        CLEAR: begin
          tmo_next = tmo_reg + TO_W'(1);
          if (expired) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
          end else if (btn_none) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          tmo_next = tmo_reg + TO_W'(1);
          // A clean press beats an expiring ballot in the same cycle.
          if (btn_onehot) begin
            state_next = LOCK;
            vote_next  = 1'b1;
            idx_next   = btn_index;
          end else if (expired) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
          end else if (!btn_none) begin
            state_next   = CLEAR;
            invalid_next = 1'b1;
          end
        end
        LOCK: begin
          if (btn_none) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    ready_next = mode && ((state_next == CLEAR) || (state_next == ARMED));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      tmo_reg       <= '0;
      idx_reg       <= 2'b00;
      ballot_ready  <= 1'b0;
      vote_valid    <= 1'b0;
      invalid_press <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_reg       <= tmo_next;
      idx_reg       <= idx_next;
      ballot_ready  <= ready_next;
      vote_valid    <= vote_next;
      invalid_press <= invalid_next;
      timeout       <= timeout_next;
    end
  end

  assign incr_party_vote = idx_reg;

endmodule

// File: tb/tb_ballot_unit.sv
// Directed bench for ballot_unit: hand-computed latencies, strobe counts and party indices.
`timescale 1ns/1ps

module tb_ballot_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic       enable_ballot;
  logic [3:0] party_btn;
  logic       ballot_ready;
  logic       vote_valid;
  logic [1:0] incr_party_vote;
  logic       invalid_press;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int invalid_cnt = 0;
  int timeout_cnt = 0;
  int last_idx = -1;

  ballot_unit #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .enable_ballot   (enable_ballot),
    .party_btn       (party_btn),
    .ballot_ready    (ballot_ready),
    .vote_valid      (vote_valid),
    .incr_party_vote (incr_party_vote),
    .invalid_press   (invalid_press),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vote_valid) begin
      strobe_cnt++;
      last_idx = int'(incr_party_vote);
    end
    if (invalid_press) invalid_cnt++;
    if (timeout) timeout_cnt++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s = %0d", tag, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue();
    @(negedge clk);
    enable_ballot = 1'b1;
    @(negedge clk);
    enable_ballot = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    mode = 1'b1;
    enable_ballot = 1'b0;
    party_btn = 4'b1111;

    // Reset with every button held
    tick(3);
    chk("rst_ready", int'(ballot_ready), 0);
    chk("rst_valid", int'(vote_valid), 0);
    chk("rst_idx", int'(incr_party_vote), 0);
    chk("rst_invalid", int'(invalid_press), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b1;
    tick(20);
    chk("no_enable_strobes", strobe_cnt, 0);
    chk("no_enable_ready", int'(ballot_ready), 0);
    party_btn = 4'b0000;
    tick(10);
    chk("release_strobes", strobe_cnt, 0);

    // Clean press of party 2, latency E0+D+2
    issue();
    tick(3);
    chk("armed_ready", int'(ballot_ready), 1);
    party_btn = 4'b0100;
    tick(6);
    chk("lat_early_valid", int'(vote_valid), 0);
    chk("lat_early_ready", int'(ballot_ready), 1);
    tick(1);
    chk("lat_valid", int'(vote_valid), 1);
    chk("lat_idx", int'(incr_party_vote), 2);
    chk("lat_ready_drop", int'(ballot_ready), 0);
    tick(1);
    chk("lat_valid_end", int'(vote_valid), 0);
    party_btn = 4'b0000;
    tick(10);

    // Second press without a new ballot
    party_btn = 4'b0001;
    tick(12);
    party_btn = 4'b0000;
    tick(10);
    chk("second_press_strobes", strobe_cnt, 1);
    chk("second_press_idx", int'(incr_party_vote), 2);

    // Button held while ballot issued
    party_btn = 4'b0001;
    tick(10);
    issue();
    tick(12);
    chk("held_ready", int'(ballot_ready), 1);
    chk("held_strobes", strobe_cnt, 1);
    party_btn = 4'b0000;
    tick(10);
    party_btn = 4'b1000;
    tick(12);
    chk("btn3_strobes", strobe_cnt, 2);
    chk("btn3_idx", last_idx, 3);
    party_btn = 4'b0000;
    tick(10);

    // Two buttons at once
    issue();
    tick(5);
    party_btn = 4'b0011;
    tick(12);
    chk("multi_invalid", invalid_cnt, 1);
    chk("multi_strobes", strobe_cnt, 2);
    chk("multi_ready", int'(ballot_ready), 1);
    party_btn = 4'b0000;
    tick(10);
    party_btn = 4'b0010;
    tick(12);
    chk("btn1_strobes", strobe_cnt, 3);
    chk("btn1_idx", last_idx, 1);
    party_btn = 4'b0000;
    tick(10);

    // 3-cycle bounces, then let the ballot expire
    issue();
    tick(3);
    repeat (3) begin
      party_btn = 4'b0100;
      tick(3);
      party_btn = 4'b0000;
      tick(3);
    end
    tick(10);
    chk("bounce_strobes", strobe_cnt, 3);
    chk("bounce_ready", int'(ballot_ready), 1);
    tick(70);
    chk("bounce_timeout", timeout_cnt, 1);
    chk("bounce_timeout_ready", int'(ballot_ready), 0);

    // Exact timeout edge
    issue();
    tick(63);
    chk("tmo_before", int'(timeout), 0);
    chk("tmo_before_ready", int'(ballot_ready), 1);
    tick(1);
    chk("tmo_pulse", int'(timeout), 1);
    chk("tmo_ready_drop", int'(ballot_ready), 0);
    tick(1);
    chk("tmo_after", int'(timeout), 0);
    chk("tmo_strobes", strobe_cnt, 3);

    // Result mode mid-ARMED
    issue();
    tick(5);
    mode = 1'b0;
    tick(2);
    chk("mode_ready", int'(ballot_ready), 0);
    mode = 1'b1;
    tick(3);
    party_btn = 4'b0100;
    tick(12);
    party_btn = 4'b0000;
    tick(10);
    chk("mode_strobes", strobe_cnt, 3);
    chk("mode_timeouts", timeout_cnt, 2);

    // Async reset mid-ballot
    issue();
    tick(3);
    party_btn = 4'b0100;
    tick(4);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ready", int'(ballot_ready), 0);
    party_btn = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(15);
    chk("async_rst_strobes", strobe_cnt, 3);
    chk("async_rst_idx", int'(incr_party_vote), 0);

    // 16 back-to-back ballots
    for (int i = 0; i < 16; i++) begin
      issue();
      tick(3);
      party_btn = 4'b0001 << (i % 4);
      tick(10);
      chk($sformatf("seq%0d_idx", i), last_idx, i % 4);
      party_btn = 4'b0000;
      tick(8);
    end
    chk("seq_strobes", strobe_cnt, 19);
    chk("seq_invalid", invalid_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
